// File: rtl/encoder42_serial.sv
// Serial 4:2 priority encoder: captures a request vector and streams out one
// beat per set bit (highest index first), or a single "none" beat for zero.
module encoder42_serial (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] d,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] y,
  output logic       last,
  output logic       none
);

  typedef enum logic {IDLE, SERVE} state_t;

  state_t     state_q, state_d;
  logic [3:0] pend_q, pend_d;
  logic       zflag_q, zflag_d;

  logic       accept;
  logic       consume;
  logic       onehot;
  logic [1:0] idx;

  always_comb begin
    idx = 2'd0;
    if (pend_q[3])      idx = 2'd3;
    else if (pend_q[2]) idx = 2'd2;
    else if (pend_q[1]) idx = 2'd1;
  end

  // Exactly one bit left means the beat about to go out is the final one.
  assign onehot = (pend_q != 4'd0) && ((pend_q & (pend_q - 4'd1)) == 4'd0);

  // Enable is active-low; en=1 gates both handshakes, which freezes all state.
  assign in_ready  = (state_q == IDLE) && !en && !rst;
  assign out_valid = (state_q == SERVE) && !en;
  assign y         = idx;
  assign last      = out_valid && (zflag_q || onehot);
  assign none      = out_valid && zflag_q;

  assign accept  = in_valid && in_ready;
  assign consume = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    zflag_d = zflag_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          pend_d  = d;
          zflag_d = (d == 4'd0);
          state_d = SERVE;
        end
      end
      SERVE: begin
        if (consume) begin
          if (last) begin
            pend_d  = 4'd0;
            zflag_d = 1'b0;
            state_d = IDLE;
          end else begin
            pend_d[idx] = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= 4'd0;
      zflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      zflag_q <= zflag_d;
    end
  end

endmodule
